// File: rtl/multi_port_banked_memory_pkg.sv
// Shared types and sizing helpers for the banked memory.
// Bank/row geometry is derived from address width and bank count.
package multi_port_banked_memory_pkg;

  typedef enum logic {
    SEL_HIGH = 1'b0,
    SEL_LOW  = 1'b1
  } bank_sel_e;

  // Ceiling log2, exact for powers of two.
  function automatic int clog2_pow2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int bank_bits(input int nb);
    return clog2_pow2(nb);
  endfunction

  function automatic int row_bits(input int at, input int nb);
    return at - clog2_pow2(nb);
  endfunction

  function automatic int depth_per_bank(input int at, input int nb);
    return (1 << at) / nb;
  endfunction

  localparam int BANK_BITS      = bank_bits(4);
  localparam int ROW_BITS       = row_bits(5, 4);
  localparam int DEPTH_PER_BANK = depth_per_bank(5, 4);

endpackage

// File: rtl/multi_port_banked_memory_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr_i and wraps upward.
// Ports: req_i, ptr_i in; one-hot gnt_o, gnt index idx_o, valid_o out.
module rr_arbiter #(
  parameter int NUM_PORT = 2,
  parameter int PW       = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic [NUM_PORT-1:0] req_i,
  input  logic [PW-1:0]       ptr_i,
  output logic [NUM_PORT-1:0] gnt_o,
  output logic [PW-1:0]       idx_o,
  output logic                valid_o
);

  always_comb begin
    int c;
    c       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_PORT; i++) begin
      c = (int'(ptr_i) + i) % NUM_PORT;
      if (!valid_o && req_i[c]) begin
        valid_o  = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/multi_port_banked_memory.sv
// N-port interleaved banked RAM, per-bank round-robin arbitration.
// Ports: i_req/i_we/i_addr/i_din in, o_gnt, o_rvalid, o_dout, o_conflict_cnt out.
module multi_port_banked_memory
  import multi_port_banked_memory_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int ADDR_TOTAL   = 5,
  parameter int NUM_BANK     = 4,
  parameter int NUM_PORT     = 2,
  parameter int BANK_SEL_LOW = 1,
  parameter int CNT_W        = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_PORT-1:0]        i_req,
  input  logic [NUM_PORT-1:0]        i_we,
  input  logic [NUM_PORT*ADDR_TOTAL-1:0] i_addr,
  input  logic [NUM_PORT*WIDTH-1:0]  i_din,
  output logic [NUM_PORT-1:0]        o_gnt,
  output logic [NUM_PORT-1:0]        o_rvalid,
  output logic [NUM_PORT*WIDTH-1:0]  o_dout,
  output logic [CNT_W-1:0]           o_conflict_cnt
);

  localparam int BB    = bank_bits(NUM_BANK);
  localparam int RB    = row_bits(ADDR_TOTAL, NUM_BANK);
  localparam int DEPTH = depth_per_bank(ADDR_TOTAL, NUM_BANK);
  localparam int BW    = (BB > 0) ? BB : 1;
  localparam int RW    = (RB > 0) ? RB : 1;
  localparam int PW    = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam bank_sel_e SEL = (BANK_SEL_LOW != 0) ? SEL_LOW : SEL_HIGH;

  if (WIDTH < 1 || CNT_W < 1 || ADDR_TOTAL < 1) begin : g_bad_w
    $error("multi_port_banked_memory: bad WIDTH/CNT_W/ADDR_TOTAL");
  end
  if (NUM_BANK < 2 || (NUM_BANK & (NUM_BANK - 1)) != 0
      || NUM_BANK > (1 << ADDR_TOTAL)) begin : g_bad_nb
    $error("multi_port_banked_memory: bad NUM_BANK");
  end
  if (NUM_PORT < 2 || NUM_PORT > 8) begin : g_bad_np
    $error("multi_port_banked_memory: bad NUM_PORT");
  end
  if (BANK_SEL_LOW != 0 && BANK_SEL_LOW != 1) begin : g_bad_sel
    $error("multi_port_banked_memory: bad BANK_SEL_LOW");
  end

  logic [BW-1:0]       bank_p [NUM_PORT];
  logic [RW-1:0]       row_p  [NUM_PORT];
  logic [NUM_PORT-1:0] gnt_bank [NUM_BANK];
  logic [WIDTH-1:0]    bank_rdata [NUM_BANK];
  logic [NUM_PORT-1:0] gnt_raw;

  logic [NUM_PORT-1:0]       rvalid_q, rvalid_d;
  logic [NUM_PORT*WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  // Address split into bank and row per port.
  always_comb begin
    int a;
    a = 0;
    for (int p = 0; p < NUM_PORT; p++) begin
      a = int'(i_addr[p*ADDR_TOTAL +: ADDR_TOTAL]);
      if (SEL == SEL_LOW) begin
        bank_p[p] = BW'(a % NUM_BANK);
        row_p[p]  = RW'(a >> BB);
      end else begin
        bank_p[p] = BW'(a >> RB);
        row_p[p]  = RW'(a % DEPTH);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [NUM_PORT-1:0] breq, bgnt;
    logic [PW-1:0]       bidx;
    logic                bvld;
    logic [PW-1:0]       rr_q, rr_d;
    logic [RW-1:0]       brow;
    logic [WIDTH-1:0]    bwdata;
    logic                bwe;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    always_comb begin
      for (int p = 0; p < NUM_PORT; p++) begin
        breq[p] = i_req[p] && (bank_p[p] == BW'(b));
      end
    end

    rr_arbiter #(
      .NUM_PORT (NUM_PORT),
      .PW       (PW)
    ) u_arb (
      .req_i   (breq),
      .ptr_i   (rr_q),
      .gnt_o   (bgnt),
      .idx_o   (bidx),
      .valid_o (bvld)
    );

    // The granted port owns this bank's single access slot.
    always_comb begin
      brow   = row_p[bidx];
      bwdata = i_din[int'(bidx)*WIDTH +: WIDTH];
      bwe    = i_rst_n && bvld && i_we[bidx];
      rr_d   = rr_q;
      if (bvld) rr_d = PW'((int'(bidx) + 1) % NUM_PORT);
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) rr_q <= '0;
      else          rr_q <= rr_d;
    end

    // Storage is never reset; contents survive i_rst_n.
    always_ff @(posedge i_clk) begin
      if (bwe) mem_q[brow] <= bwdata;
    end

    assign bank_rdata[b] = mem_q[brow];
    assign gnt_bank[b]   = bgnt;
  end

  always_comb begin
    gnt_raw = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      gnt_raw = gnt_raw | gnt_bank[b];
    end
  end

  assign o_gnt = i_rst_n ? gnt_raw : '0;

  always_comb begin
    rvalid_d = '0;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (o_gnt[p] && !i_we[p]) begin
        rvalid_d[p]             = 1'b1;
        dout_d[p*WIDTH +: WIDTH] = bank_rdata[bank_p[p]];
      end
    end
    if (|(i_req & ~gnt_raw) && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rvalid_q <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_rvalid       = rvalid_q;
  assign o_dout         = dout_q;
  assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_multi_port_banked_memory.sv
// Self-checking bench: directed scenarios plus random traffic
// compared against a flat-memory arbitration model.
module tb_multi_port_banked_memory;

  localparam int NP = 2;
  localparam int AT = 5;
  localparam int W  = 8;
  localparam int NB = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NP-1:0]    req, we;
  logic [NP*AT-1:0] addr;
  logic [NP*W-1:0]  din;
  logic [NP-1:0]    gnt, rvalid;
  logic [NP*W-1:0]  dout;
  logic [CW-1:0]    cnt;

  multi_port_banked_memory #(
    .WIDTH        (W),
    .ADDR_TOTAL   (AT),
    .NUM_BANK     (NB),
    .NUM_PORT     (NP),
    .BANK_SEL_LOW (1),
    .CNT_W        (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_we           (we),
    .i_addr         (addr),
    .i_din          (din),
    .o_gnt          (gnt),
    .o_rvalid       (rvalid),
    .o_dout         (dout),
    .o_conflict_cnt (cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0]  mem_m [1<<AT];
  int            rr_m [NB];
  logic [NP-1:0] rv_m, gnt_m, gnt_seen;
  logic [W-1:0]  dout_m [NP];
  int            cnt_m;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_port(int p, bit r, bit w, int a, int d);
    req[p]          = r;
    we[p]           = w;
    addr[p*AT +: AT] = AT'(a);
    din[p*W +: W]   = W'(d);
  endtask

  task automatic idle();
    req = '0; we = '0; addr = '0; din = '0;
  endtask

  // One clock: grant check before the edge, outputs after it.
  task automatic tick();
    int  rr_n [NB];
    int  p, a;
    bit  found;
    @(negedge clk);
    gnt_m = '0;
    rr_n  = rr_m;
    if (rst_n) begin
      for (int b = 0; b < NB; b++) begin
        found = 1'b0;
        for (int k = 0; k < NP; k++) begin
          p = (rr_m[b] + k) % NP;
          if (!found && req[p] && (int'(addr[p*AT +: AT]) % NB) == b) begin
            found    = 1'b1;
            gnt_m[p] = 1'b1;
            rr_n[b]  = (p + 1) % NP;
          end
        end
      end
    end
    gnt_seen = gnt;
    check("gnt", gnt, gnt_m);
    @(posedge clk);
    if (!rst_n) begin
      rv_m  = '0;
      cnt_m = 0;
      for (int q = 0; q < NP; q++) dout_m[q] = '0;
      for (int b = 0; b < NB; b++) rr_m[b] = 0;
    end else begin
      rv_m = '0;
      for (int q = 0; q < NP; q++) begin
        if (gnt_m[q]) begin
          a = int'(addr[q*AT +: AT]);
          if (we[q]) mem_m[a] = din[q*W +: W];
          else begin
            rv_m[q]   = 1'b1;
            dout_m[q] = mem_m[a];
          end
        end
      end
      if ((req & ~gnt_m) != '0 && cnt_m < (1 << CW) - 1) cnt_m++;
      rr_m = rr_n;
    end
    #1;
    check("rvalid", rvalid, rv_m);
    check("dout0", dout[W-1:0], dout_m[0]);
    check("dout1", dout[2*W-1:W], dout_m[1]);
    check("cnt", cnt, cnt_m);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
    cnt_m = 0;
    rv_m  = '0;
    for (int q = 0; q < NP; q++) dout_m[q] = '0;

    // Reset with both ports requesting.
    set_port(0, 1, 0, 0, 0);
    set_port(1, 1, 0, 1, 0);
    tick();
    tick();
    check("rst_gnt", gnt_seen, 2'b00);
    check("rst_rv", rvalid, 2'b00);
    check("rst_dout", dout, 16'h0000);
    check("rst_cnt", cnt, 4'd0);
    rst_n = 1'b1;
    idle();

    // Preload every word through port1.
    for (int a = 0; a < (1 << AT); a++) begin
      set_port(1, 1, 1, a, a ^ 8'h5A);
      tick();
    end
    idle();

    // No conflict: different banks both granted.
    set_port(0, 1, 1, 12, 8'h0C);
    set_port(1, 1, 1, 1, 8'h0B);
    tick();
    check("p2_gnt", gnt_seen, 2'b11);
    set_port(0, 1, 0, 1, 0);
    set_port(1, 1, 0, 12, 0);
    tick();
    check("p2_rv", rvalid, 2'b11);
    check("p2_dout0", dout[7:0], 8'h0B);
    check("p2_dout1", dout[15:8], 8'h0C);
    idle();
    tick();

    // Conflict on bank2.
    set_port(0, 1, 1, 22, 8'h16);
    set_port(1, 1, 1, 10, 8'h62);
    tick();
    check("p3_gnt_a", gnt_seen, 2'b01);
    set_port(0, 0, 0, 0, 0);
    tick();
    check("p3_gnt_b", gnt_seen, 2'b10);
    check("p3_cnt", cnt, 4'd1);
    set_port(0, 1, 0, 22, 0);
    set_port(1, 1, 0, 10, 0);
    tick();
    check("p3_rd_gnt", gnt_seen, 2'b01);
    check("p3_rv_a", rvalid, 2'b01);
    check("p3_dout0", dout[7:0], 8'h16);
    set_port(0, 0, 0, 0, 0);
    tick();
    check("p3_rv_b", rvalid, 2'b10);
    check("p3_dout1", dout[15:8], 8'h62);
    idle();

    // Same-port write then read.
    set_port(0, 1, 1, 5, 8'hAA);
    tick();
    set_port(0, 1, 0, 5, 0);
    tick();
    check("p4_rv0", rvalid[0], 1'b1);
    check("p4_dout0", dout[7:0], 8'hAA);
    idle();

    // Reset arriving right after a granted read.
    set_port(0, 1, 0, 12, 0);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    check("p5_rv_drop", rvalid, 2'b00);
    rst_n = 1'b1;
    set_port(0, 1, 0, 12, 0);
    tick();
    check("p5_rv", rvalid, 2'b01);
    check("p5_dout0", dout[7:0], 8'h0C);
    idle();

    // Hammer bank3 to saturate the counter.
    for (int i = 0; i < 20; i++) begin
      set_port(0, 1, 0, 3, 0);
      set_port(1, 1, 0, 7, 0);
      tick();
      check("p6_alt", gnt_seen, (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    check("p6_sat", cnt, 4'd15);

    // Random traffic; denied ports hold their request.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req[p] && !gnt_m[p])) begin
          set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 31), $urandom_range(0, 255));
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_port_banked_memory.md
Name: multi_port_banked_memory

Overview:
Single-clock, N-port, multi-bank interleaved RAM with per-bank round-robin conflict arbitration. It is the next generation of the team's dual-port multi-bank memory. Port count, bank count and bank-select mode are parameters, and every port uses a req/gnt handshake with a tagged read-valid return. It sits between several requesters (DMA, CPU, accelerator lanes) and shared on-chip storage.

Parameters:
WIDTH, 8, data word width in bits
ADDR_TOTAL, 5, total address width; 2**ADDR_TOTAL words in all banks combined
NUM_BANK, 4, bank count; power of 2, 2..2**ADDR_TOTAL
NUM_PORT, 2, requester port count, 2..8
BANK_SEL_LOW, 1, 1: bank = addr low log2(NUM_BANK) bits (interleaved); 0: bank = addr high bits (blocked)
CNT_W, 16, width of saturating conflict counter

Ports:
i_clk  in  1  single clock, rising edge
i_rst_n  in  1  synchronous reset, active low
i_req  in  NUM_PORT  per-port request
i_we  in  NUM_PORT  per-port write enable (1 write, 0 read), sampled with i_req
i_addr  in  NUM_PORT*ADDR_TOTAL  port p address at [p*ADDR_TOTAL +: ADDR_TOTAL]
i_din  in  NUM_PORT*WIDTH  port p write data at [p*WIDTH +: WIDTH]
o_gnt  out  NUM_PORT  combinational grant in the same cycle as the request
o_rvalid  out  NUM_PORT  registered; read data valid for port p
o_dout  out  NUM_PORT*WIDTH  registered read data, port p slice
o_conflict_cnt  out  CNT_W  count of cycles with at least one denied request, saturating

Behaviour:
- Reset when i_rst_n=0 at a rising edge:
  - o_rvalid=0, o_dout=0, o_conflict_cnt=0.
  - All bank round-robin pointers are set to 0.
  - Memory contents are not reset and are retained.
  - o_gnt=0 throughout the reset cycle.
- Bank and row decode:
  - BANK_SEL_LOW=1: bank = addr mod NUM_BANK, row = addr >> log2(NUM_BANK).
  - BANK_SEL_LOW=0: bank = top bits of addr, row = low bits.
  - Each bank holds 2**ADDR_TOTAL/NUM_BANK words.
- Arbitration (per bank, each cycle):
  - Candidates are the ports with i_req=1 targeting that bank.
  - Search starts at rr[b] and proceeds upward modulo NUM_PORT; the first candidate found is granted.
  - At most one grant per bank per cycle. Ports on different banks are all granted in the same cycle.
  - On a grant to port p: rr[b] <= (p+1) mod NUM_PORT. rr[b] is unchanged if the bank was idle.
- Handshake:
  - A transfer occurs when i_req&o_gnt=1 at a rising edge.
  - A denied port must hold i_req/i_we/i_addr/i_din stable until granted.
  - Worst-case wait is NUM_PORT-1 cycles; no starvation.
- Write: on a granted write, the bank row is updated at that edge. No o_rvalid is produced for writes.
- Read latency is 1 cycle:
  - A read granted at edge N sets o_rvalid[p]=1 and the o_dout slice after edge N.
  - o_rvalid[p] falls after the next edge unless another read is granted.
  - o_dout holds its last value when o_rvalid=0.
- Same-port write then read of the same address on consecutive cycles returns the new data.
- No same-cycle read/write collision is possible: a bank serves one port per cycle.
- Conflict counter: increments once per cycle in which any requesting port is denied. It saturates at 2**CNT_W-1.
- Reset mid-operation: a read granted at edge N with reset sampled at edge N+1 produces o_rvalid=0. Its data is dropped.
- Unknown or illegal parameters are rejected with an elaboration-time $error.

Decomposition:
- Package multi_port_banked_memory_pkg holds:
  - function clog2_pow2
  - localparams BANK_BITS, ROW_BITS, DEPTH_PER_BANK as parameterised functions
  - typedef enum {SEL_HIGH, SEL_LOW}
- Sub-module rr_arbiter (parameter NUM_PORT): request vector plus pointer in, one-hot grant out.
  - One instance per bank through a generate loop.
  - Bank storage is an inline generate array of register files.

Test Plan (WIDTH=8, ADDR_TOTAL=5, NUM_BANK=4, NUM_PORT=2, BANK_SEL_LOW=1, CNT_W=4):
1. Reset: i_rst_n=0 for 2 cycles with i_req=2'b11 -> o_gnt=0, o_rvalid=0, o_dout=0, o_conflict_cnt=0.
2. No conflict:
   - Port0 writes 0x0C@12 (bank0) and port1 writes 0x0B@1 (bank1) in the same cycle -> o_gnt=2'b11.
   - Next cycle port0 reads 1 and port1 reads 12 -> one cycle later o_rvalid=2'b11, dout0=0x0B, dout1=0x0C.
3. Conflict:
   - Port0 writes 0x16@22 and port1 writes 0x62@10 (both bank2) -> cycle N o_gnt=2'b01, cycle N+1 o_gnt=2'b10, o_conflict_cnt=1.
   - Both then read bank2 -> port0 granted first (rr=0). Reads return 0x16 and 0x62 on successive cycles.
4. Read-after-write same port: write 0xAA@5 at edge N, read 5 at edge N+1 -> o_rvalid[0]=1, dout0=0xAA after edge N+1.
5. Reset mid-read:
   - Read of 12 is granted at edge N, and i_rst_n=0 is sampled at edge N+1 -> o_rvalid=0.
   - After reset release, reading 12 returns 0x0C (contents retained).
6. Saturation: both ports hammer bank3 for 20 cycles -> grants alternate 01/10, o_conflict_cnt stops at 15 and holds.
